rr_trace_marshaller: RTL and testbench

- Record-side packer; the inverse of the replay-side trace demarshaller tree.
- Takes one snapshot per cycle: every channel's logb_valid, logb_data at fixed offsets, and loge_valid.
- Compacts the data of the valid logb channels into a contiguous LSB-first field and emits a single packed stream word.
- Output feeds the trace FIFO/PCIe writer; the replay decoder consumes exactly this layout.

---
 rtl/rr_trace_marshaller_pkg.sv | 54 +++++
 rtl/rr_trace_marshaller_if.sv | 44 ++++
 rtl/rr_trace_marshaller_pipe_reg.sv | 39 +++
 rtl/rr_trace_marshaller.sv | 134 +++++++++++++
 tb/tb_rr_trace_marshaller.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_trace_marshaller_pkg.sv
// Shared record/replay trace definitions: channel width encoding,
// stream word field order and width/offset helpers for encoder and decoder.
package rr_trace_marshaller_pkg;

  localparam int RR_CHANNEL_WIDTH_BITS = 8;
  localparam int RR_MAX_CHANNELS = 16;

  typedef logic [RR_MAX_CHANNELS-1:0]
                [RR_CHANNEL_WIDTH_BITS-1:0] rr_widths_t;

  // index0=8, index1=16, index2=32, index3=4
  localparam rr_widths_t RR_DEF_WIDTHS =
    rr_widths_t'({8'd4, 8'd32, 8'd16, 8'd8});

  // Stream word, from LSB: logb_valid, loge_valid, packed data.
  function automatic int rr_logb_lsb();
    return 0;
  endfunction

  function automatic int rr_loge_lsb(input int nlogb);
    return nlogb;
  endfunction

  function automatic int rr_data_lsb(input int nlogb,
                                     input int nloge);
    return nlogb + nloge;
  endfunction

  function automatic int def_sum_width(input rr_widths_t w,
                                       input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += int'(w[i]);
    return s;
  endfunction

  function automatic int def_get_offset(input rr_widths_t w,
                                        input int idx);
    int s;
    s = 0;
    for (int i = 0; i < idx; i++) s += int'(w[i]);
    return s;
  endfunction

  function automatic bit def_any_zero(input rr_widths_t w,
                                      input int n);
    bit z;
    z = 1'b0;
    for (int i = 0; i < n; i++)
      if (w[i] == '0) z = 1'b1;
    return z;
  endfunction

endpackage

// File: rtl/rr_trace_marshaller_if.sv
// Snapshot-in / packed-word-out stream bundle of the trace marshaller.
// slave: marshaller view; master: producer/consumer view.
interface rr_trace_marshaller_if #(
  parameter int LOGB_CNT = 4,
  parameter int LOGE_CNT = 4,
  parameter int FULL_W   = 60,
  parameter int OFF_W    = 6
) ();

  logic                         in_valid;
  logic                         in_ready;
  logic [LOGB_CNT-1:0]          in_logb_valid;
  logic [FULL_W-1:0]            in_logb_data;
  logic [LOGE_CNT-1:0]          in_loge_valid;
  logic                         out_valid;
  logic                         out_ready;
  logic [LOGB_CNT+LOGE_CNT+FULL_W-1:0] out_data;
  logic [OFF_W-1:0]             out_len;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_logb_valid,
    input  in_logb_data,
    input  in_loge_valid,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_len
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_logb_valid,
    output in_logb_data,
    output in_loge_valid,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_len
  );

endinterface

// File: rtl/rr_trace_marshaller_pipe_reg.sv
// rr_pipe_reg: one valid/ready register stage, full throughput.
// Ports: valid_i/ready_o/data_i upstream, valid_o/ready_i/data_o downstream.
module rr_pipe_reg
  import rr_trace_marshaller_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (ready_o && valid_i) begin
      data_q <= data_i;
    end
  end

endmodule

// File: rtl/rr_trace_marshaller.sv
// Record-side trace packer: compacts valid logb channel data LSB-first.
// Ports: clk, rstn, bus (snapshot in / packed word out), pkt_cnt.
module rr_trace_marshaller
  import rr_trace_marshaller_pkg::*;
#(
  parameter int LOGB_CHANNEL_CNT = 4,
  parameter logic [LOGB_CHANNEL_CNT-1:0]
                  [RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
    {8'd4, 8'd32, 8'd16, 8'd8},
  parameter int LOGE_CHANNEL_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  rr_trace_marshaller_if.slave  bus,
  output logic [31:0]           pkt_cnt
);

  localparam rr_widths_t WID = rr_widths_t'(CHANNEL_WIDTHS);
  localparam int NB = LOGB_CHANNEL_CNT;
  localparam int NE = LOGE_CHANNEL_CNT;
  localparam int FULL_WIDTH = def_sum_width(WID, NB);
  localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1);
  localparam int OW = OFFSET_WIDTH;
  localparam int S1W = NB * OW + OW + FULL_WIDTH + NE + NB;
  localparam int S2W = FULL_WIDTH + OW + NE + NB;

  if (NB == 0) begin : g_err_nb
    $error("LOGB_CHANNEL_CNT must be nonzero");
  end
  if (NE == 0) begin : g_err_ne
    $error("LOGE_CHANNEL_CNT must be nonzero");
  end
  if (NB > RR_MAX_CHANNELS) begin : g_err_max
    $error("LOGB_CHANNEL_CNT exceeds RR_MAX_CHANNELS");
  end
  if (def_any_zero(WID, NB)) begin : g_err_w
    $error("CHANNEL_WIDTHS entries must be nonzero");
  end

  logic [NB-1:0][OW-1:0] off_d;
  logic [OW-1:0]         len_d;

  // Running prefix sum over valid channels.
  always_comb begin
    off_d = '0;
    len_d = '0;
    for (int j = 0; j < NB; j++) begin
      off_d[j] = len_d;
      if (bus.in_logb_valid[j])
        len_d = len_d + OW'(WID[j]);
    end
  end

  logic           s1_vin;
  logic           s1_rdy;
  logic           s1_valid;
  logic           s2_rdy;
  logic [S1W-1:0] s1_din;
  logic [S1W-1:0] s1_q;

  // Empty snapshots handshake normally but never occupy S1.
  assign s1_vin = bus.in_valid &&
                  ((|bus.in_logb_valid) || (|bus.in_loge_valid));
  assign bus.in_ready = rstn && s1_rdy;
  assign s1_din = {off_d, len_d, bus.in_logb_data,
                   bus.in_loge_valid, bus.in_logb_valid};

  rr_pipe_reg #(.DATA_WIDTH(S1W)) u_s1 (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (s1_vin),
    .ready_o (s1_rdy),
    .data_i  (s1_din),
    .valid_o (s1_valid),
    .ready_i (s2_rdy),
    .data_o  (s1_q)
  );

  logic [NB-1:0][OW-1:0]  s1_off;
  logic [OW-1:0]          s1_len;
  logic [FULL_WIDTH-1:0]  s1_data;
  logic [NE-1:0]          s1_loge;
  logic [NB-1:0]          s1_logb;

  assign {s1_off, s1_len, s1_data, s1_loge, s1_logb} = s1_q;

  logic [FULL_WIDTH-1:0] packed_d;

  // Mask each channel out of its fixed slot, move it to its offset.
  always_comb begin
    packed_d = '0;
    for (int j = 0; j < NB; j++) begin
      if (s1_logb[j])
        packed_d = packed_d |
          (((s1_data >> def_get_offset(WID, j)) &
            ~({FULL_WIDTH{1'b1}} << WID[j])) << s1_off[j]);
    end
  end

  logic           s2_valid;
  logic [S2W-1:0] s2_din;
  logic [S2W-1:0] s2_q;

  assign s2_din = {packed_d, s1_len, s1_loge, s1_logb};

  rr_pipe_reg #(.DATA_WIDTH(S2W)) u_s2 (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (s1_valid),
    .ready_o (s2_rdy),
    .data_i  (s2_din),
    .valid_o (s2_valid),
    .ready_i (bus.out_ready),
    .data_o  (s2_q)
  );

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = {s2_q[S2W-1 -: FULL_WIDTH],
                          s2_q[NE+NB-1:0]};
  assign bus.out_len   = s2_q[NE+NB +: OW];

  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_cnt_q <= '0;
    end else if (s2_valid && bus.out_ready) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_rr_trace_marshaller.sv
// Self-checking bench for rr_trace_marshaller with a packet scoreboard.
// Default widths: ch0=8, ch1=16, ch2=32, ch3=4.
module tb_rr_trace_marshaller;
  import rr_trace_marshaller_pkg::*;

  localparam int NB = 4;
  localparam int NE = 4;
  localparam int FW = 60;
  localparam int LW = 6;
  localparam int DW = NB + NE + FW;
  localparam int CW[4] = '{8, 16, 32, 4};
  localparam int BASE[4] = '{0, 8, 24, 56};

  typedef struct packed {
    logic [DW-1:0] d;
    logic [LW-1:0] len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pkt_cnt;

  rr_trace_marshaller_if #(
    .LOGB_CNT(NB), .LOGE_CNT(NE),
    .FULL_W(FW), .OFF_W(LW)
  ) bus ();

  rr_trace_marshaller dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t model(input logic [3:0] lb,
                                 input logic [3:0] le,
                                 input logic [FW-1:0] din);
    exp_t e;
    logic [FW-1:0] p;
    int pos;
    p = '0;
    pos = 0;
    for (int ch = 0; ch < 4; ch++) begin
      if (lb[ch]) begin
        for (int b = 0; b < CW[ch]; b++)
          p[pos+b] = din[BASE[ch]+b];
        pos += CW[ch];
      end
    end
    e.d = {p, le, lb};
    e.len = LW'(pos);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.out_valid && bus.out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: out_data=%h len=%0d required no packet",
                 bus.out_data, bus.out_len);
      end else begin
        e = q.pop_front();
        if (bus.out_data !== e.d || bus.out_len !== e.len) begin
          errors++;
          $display("FAIL sb_pkt: out_data=%h len=%0d required %h len=%0d",
                   bus.out_data, bus.out_len, e.d, e.len);
        end
      end
    end
  end

  task automatic send(input logic [3:0] lb,
                      input logic [3:0] le,
                      input logic [FW-1:0] din);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_logb_valid = lb;
    bus.in_loge_valid = le;
    bus.in_logb_data = din;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if ((lb | le) != 4'd0) q.push_back(model(lb, le, din));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 required 1");
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_logb_valid = 4'hF;
    bus.in_loge_valid = 4'hF;
    bus.in_logb_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b required 0", bus.out_valid);
    end
    checks++;
    if (pkt_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_pkt_cnt: got %0d required 0", pkt_cnt);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready: got %b required 0", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_all_valid();
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(4'hF, 4'hF, {4'h7, 32'hDEADBEEF, 16'h1234, 8'hA5});
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL all_t1_valid: got %b required 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_data[67:8] !== 60'h7DEADBEEF1234A5) begin
      errors++;
      $display("FAIL all_packed: valid=%b data=%h required 1 %h",
               bus.out_valid, bus.out_data[67:8], 60'h7DEADBEEF1234A5);
    end
    checks++;
    if (bus.out_len !== 6'd60) begin
      errors++;
      $display("FAIL all_len: got %0d required 60", bus.out_len);
    end
    checks++;
    if (bus.out_data[7:0] !== 8'hFF) begin
      errors++;
      $display("FAIL all_flags: got %h required ff", bus.out_data[7:0]);
    end
  endtask

  task automatic test_sparse();
    @(posedge clk);
    #1;
    send(4'b1010, 4'h0, {4'h7, 32'hFFFFFFFF, 16'h1234, 8'hFF});
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_data[27:8] !== 20'h71234 ||
        bus.out_data[67:28] !== 40'h0) begin
      errors++;
      $display("FAIL sparse_packed: valid=%b data=%h required 1 %h",
               bus.out_valid, bus.out_data[67:8], 60'h71234);
    end
    checks++;
    if (bus.out_len !== 6'd20) begin
      errors++;
      $display("FAIL sparse_len: got %0d required 20", bus.out_len);
    end
    checks++;
    if (bus.out_data[7:0] !== 8'h0A) begin
      errors++;
      $display("FAIL sparse_flags: got %h required 0a", bus.out_data[7:0]);
    end
  endtask

  task automatic test_loge_only();
    logic [31:0] base;
    @(posedge clk);
    #1;
    base = pkt_cnt;
    send(4'h0, 4'b0101, FW'({$urandom(), $urandom()}));
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 68'h50 ||
        bus.out_len !== 6'd0) begin
      errors++;
      $display("FAIL loge_word: valid=%b data=%h len=%0d required 1 50 0",
               bus.out_valid, bus.out_data, bus.out_len);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pkt_cnt !== base + 32'd1) begin
      errors++;
      $display("FAIL loge_cnt: got %0d required %0d", pkt_cnt, base + 1);
    end
  endtask

  task automatic test_empty();
    logic [31:0] base;
    @(posedge clk);
    #1;
    base = pkt_cnt;
    bus.in_valid = 1'b1;
    bus.in_logb_valid = 4'h0;
    bus.in_loge_valid = 4'h0;
    bus.in_logb_data = FW'({$urandom(), $urandom()});
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty_ready: got %b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_out_valid: cycle %0d got %b required 0",
                 c, bus.out_valid);
      end
    end
    checks++;
    if (pkt_cnt !== base) begin
      errors++;
      $display("FAIL empty_cnt: got %0d required %0d", pkt_cnt, base);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]    lb[6];
    logic [3:0]    le[6];
    logic [FW-1:0] din[6];
    logic [31:0]   base;
    exp_t          e0;
    int            acc;
    for (int i = 0; i < 6; i++) begin
      lb[i] = 4'(i + 1);
      le[i] = 4'(5 - i);
      din[i] = FW'({$urandom(), $urandom()});
    end
    e0 = model(lb[0], le[0], din[0]);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    base = pkt_cnt;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_logb_valid = lb[acc];
      bus.in_loge_valid = le[acc];
      bus.in_logb_data = din[acc];
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(model(lb[acc], le[acc], din[acc]));
        acc++;
      end
      if (c >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e0.d ||
            bus.out_len !== e0.len) begin
          errors++;
          $display("FAIL b2b_hold: valid=%b data=%h required 1 %h",
                   bus.out_valid, bus.out_data, e0.d);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (acc !== 2) begin
      errors++;
      $display("FAIL b2b_accepted: got %0d required 2", acc);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_in_ready: got %b required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_logb_valid = lb[acc];
      bus.in_loge_valid = le[acc];
      bus.in_logb_data = din[acc];
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(model(lb[acc], le[acc], din[acc]));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (acc !== 6 || pkt_cnt !== base + 32'd6) begin
      errors++;
      $display("FAIL b2b_cnt: acc=%0d pkt_cnt=%0d required 6 %0d",
               acc, pkt_cnt, base + 6);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(4'hF, 4'h1, FW'({$urandom(), $urandom()}));
    send(4'h3, 4'h2, FW'({$urandom(), $urandom()}));
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    q.delete();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_valid: got %b required 0", bus.out_valid);
    end
    checks++;
    if (pkt_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_rst_cnt: got %0d required 0", pkt_cnt);
    end
    @(posedge clk);
    #1;
    send(4'b0101, 4'h0, {4'h9, 32'hCAFEF00D, 16'hBEEF, 8'h3C});
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_t1_valid: got %b required 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_data[67:8] !== 60'hCAFEF00D3C ||
        bus.out_len !== 6'd40) begin
      errors++;
      $display("FAIL mid_post_pkt: valid=%b data=%h len=%0d required 1 %h 40",
               bus.out_valid, bus.out_data[67:8], bus.out_len,
               60'hCAFEF00D3C);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_logb_valid = '0;
    bus.in_loge_valid = '0;
    bus.in_logb_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_all_valid();
    test_sparse();
    test_loge_only();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending=%0d required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
